// File: rtl/correlator_sequencer_pkg.sv
// Shared TART correlator configuration.
// Slot count, slot-address width and the default write lag live here so the
// sequencer and the correlator pipeline agree on them.
package correlator_sequencer_pkg;

  localparam int TART_TRATE = 12;  // accumulator slots per sample sweep
  localparam int TART_TBITS = 4;   // slot-address width, 2**TBITS >= TRATE
  localparam int TART_WLAT  = 3;   // rd -> wr lag, matches correlator read/add/write depth

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SWEEP = 1'b1
  } seq_state_t;

endpackage

// File: rtl/correlator_sequencer_shift_reg_delay.sv
// shift_reg_delay: DEPTH-stage register chain of WIDTH bits, cleared by reset.
// Ports: clk_x/rst_n clock and async active-low reset, din input word,
//        dout = din delayed by DEPTH clocks.
module shift_reg_delay #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 3
) (
  input  logic             clk_x,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] pipe;

  always_ff @(posedge clk_x or negedge rst_n) begin
    if (!rst_n) begin
      pipe <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/correlator_sequencer.sv
// correlator_sequencer: control stage ahead of the time-multiplexed correlators.
// Latches each 24-antenna sample, sweeps the TRATE accumulator slots, counts
// samples per block and schedules the bank switch.
// Ports:
//   clk_x, rst_n      clock, async active-low reset
//   blocksize         log2(samples per accumulation block)
//   strobe            new sample pulse on re_in/im_in
//   en, sw            data valid / accumulator clear to the correlators
//   re, im            latched sample, stable over a sweep
//   rd, wr            accumulator read slot, write slot (rd delayed WLAT)
//   bank, swap        accumulating bank index, pulse when the other bank is done
//   overrun           sticky, a strobe arrived mid-sweep and was dropped
module correlator_sequencer
  import correlator_sequencer_pkg::*;
#(
  parameter int TRATE = TART_TRATE,
  parameter int TBITS = TART_TBITS,
  parameter int TSB   = TBITS-1,
  parameter int WLAT  = TART_WLAT,
  parameter int BBITS = 5
) (
  input  logic             clk_x,
  input  logic             rst_n,
  input  logic [BBITS-1:0] blocksize,
  input  logic             strobe,
  input  logic [23:0]      re_in,
  input  logic [23:0]      im_in,
  output logic             en,
  output logic             sw,
  output logic [23:0]      re,
  output logic [23:0]      im,
  output logic [TSB:0]     rd,
  output logic [TSB:0]     wr,
  output logic             bank,
  output logic             swap,
  output logic             overrun
);

  // Counter wide enough for 2**(2**BBITS-1) samples.
  localparam int            CW   = 2**BBITS;
  localparam logic [TSB:0]  LAST = TBITS'(TRATE-1);

  seq_state_t       state, state_nxt;
  logic             accept, drop, last_slot, first, blk_done;
  logic [BBITS-1:0] blk;
  logic [CW-1:0]    cnt;

  assign last_slot = (rd == LAST);
  assign blk_done  = (cnt == (CW'(1) << blk));

  always_ff @(posedge clk_x or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // A strobe is taken when idle, or on the last slot so sweeps can abut.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    drop      = 1'b0;
    case (state)
      S_IDLE: begin
        if (strobe) begin
          accept    = 1'b1;
          state_nxt = S_SWEEP;
        end
      end
      S_SWEEP: begin
        if (last_slot) begin
          if (strobe) accept = 1'b1;
          else        state_nxt = S_IDLE;
        end else if (strobe) begin
          drop = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_x or negedge rst_n) begin
    if (!rst_n) begin
      en      <= 1'b0;
      sw      <= 1'b0;
      re      <= '0;
      im      <= '0;
      rd      <= '0;
      bank    <= 1'b0;
      swap    <= 1'b0;
      overrun <= 1'b0;
      first   <= 1'b1;
      cnt     <= '0;
      blk     <= '0;
    end else begin
      swap <= 1'b0;
      if (drop) overrun <= 1'b1;
      if (accept) begin
        en <= 1'b1;
        rd <= '0;
        re <= re_in;
        im <= im_in;
        if (first) begin
          // Post-reset sweep clears stale accumulators; nothing to hand over.
          sw    <= 1'b1;
          first <= 1'b0;
          cnt   <= CW'(1);
          blk   <= blocksize;
        end else if (blk_done) begin
          // This sample opens a new block in the other bank.
          sw    <= 1'b1;
          bank  <= ~bank;
          swap  <= 1'b1;
          cnt   <= CW'(1);
          blk   <= blocksize;
        end else begin
          sw  <= 1'b0;
          cnt <= cnt + 1'b1;
        end
      end else if (state == S_SWEEP) begin
        if (last_slot) begin
          en <= 1'b0;
          sw <= 1'b0;
          rd <= '0;
        end else begin
          rd <= rd + 1'b1;
        end
      end
    end
  end

  // wr trails rd unconditionally; the correlator's own valid gates writes.
  shift_reg_delay #(
    .WIDTH (TBITS),
    .DEPTH (WLAT)
  ) u_wr_dly (
    .clk_x (clk_x),
    .rst_n (rst_n),
    .din   (rd),
    .dout  (wr)
  );

endmodule

// File: tb/tb_correlator_sequencer.sv
// Directed bench for correlator_sequencer: first sweep, block switching with
// blocksize 2, dropped strobe, mid-block blocksize change, async reset
// mid-sweep and blocksize 0.
module tb_correlator_sequencer;

  localparam int TRATE = 12;
  localparam int WLAT  = 3;

  logic        clk_x = 1'b0;
  logic        rst_n = 1'b1;
  logic [4:0]  blocksize = 5'd2;
  logic        strobe = 1'b0;
  logic [23:0] re_in = '0, im_in = '0;
  logic        en, sw, bank, swap, overrun;
  logic [23:0] re, im;
  logic [3:0]  rd, wr;

  int nvec = 0;
  int nerr = 0;
  logic exp_ovr = 1'b0;

  always #5 clk_x = ~clk_x;

  correlator_sequencer dut (
    .clk_x     (clk_x),
    .rst_n     (rst_n),
    .blocksize (blocksize),
    .strobe    (strobe),
    .re_in     (re_in),
    .im_in     (im_in),
    .en        (en),
    .sw        (sw),
    .re        (re),
    .im        (im),
    .rd        (rd),
    .wr        (wr),
    .bank      (bank),
    .swap      (swap),
    .overrun   (overrun)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %0h want %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_x);
    #1;
  endtask

  // Strobe one sample at the next edge and check its whole sweep. Returns in
  // the rd==TRATE-1 cycle so a following call abuts it. A drop_at >= 0
  // fires an extra strobe with different data in that slot.
  task automatic sweep(input logic [23:0] rv, input logic [23:0] iv,
                       input logic esw, input logic eswap, input logic ebank,
                       input int drop_at);
    strobe = 1'b1;
    re_in  = rv;
    im_in  = iv;
    tick();
    strobe = 1'b0;
    for (int i = 0; i < TRATE; i++) begin
      chk("en", en, 1);
      chk("rd", rd, i);
      chk("sw", sw, esw);
      chk("swap", swap, (i == 0) ? eswap : 1'b0);
      chk("bank", bank, ebank);
      chk("re", re, rv);
      chk("im", im, iv);
      chk("overrun", overrun, exp_ovr);
      if (i >= WLAT) chk("wr", wr, i - WLAT);
      if (i == drop_at) begin
        strobe = 1'b1;
        re_in  = ~rv;
        im_in  = ~iv;
        tick();
        strobe  = 1'b0;
        exp_ovr = 1'b1;
      end else if (i < TRATE-1) begin
        tick();
      end
    end
  endtask

  initial begin
    // reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst_en", en, 0);
    chk("rst_sw", sw, 0);
    chk("rst_rd", rd, 0);
    chk("rst_wr", wr, 0);
    chk("rst_re", re, 0);
    chk("rst_bank", bank, 0);
    chk("rst_swap", swap, 0);
    chk("rst_ovr", overrun, 0);
    tick();
    tick();
    #3 rst_n = 1'b1;
    tick();

    // first sweep, then blocksize=2 back-to-back: samples 1..9
    sweep(24'hA5A5A5, 24'h5A5A5A, 1, 0, 0, -1);
    for (int n = 2; n <= 9; n++) begin
      logic sw_e;
      logic bank_e;
      sw_e   = (n == 5 || n == 9);
      bank_e = (n >= 5 && n <= 8);
      sweep(24'h100000 + 24'(n), 24'h200000 + 24'(n), sw_e, sw_e, bank_e, -1);
    end
    tick();
    chk("idle_en", en, 0);
    chk("idle_rd", rd, 0);
    chk("idle_sw", sw, 0);

    // dropped strobe at rd=5 (sample 10), accepted strobe at rd=11 (sample 11)
    sweep(24'h0F0F0F, 24'hF0F0F0, 0, 0, 0, 5);
    chk("ovr_sticky", overrun, 1);
    sweep(24'h123456, 24'h654321, 0, 0, 0, -1);

    // blocksize 2->4 mid-block: samples 12,13(switch),14..28,29(switch)
    blocksize = 5'd4;
    sweep(24'h00000C, 24'h0000C0, 0, 0, 0, -1);
    sweep(24'h00000D, 24'h0000D0, 1, 1, 1, -1);
    for (int n = 14; n <= 28; n++) begin
      if (n == 28) blocksize = 5'd0;  // takes effect at sample 29's switch
      sweep(24'h300000 + 24'(n), 24'h400000 + 24'(n), 0, 0, 1, -1);
    end
    sweep(24'h00001D, 24'h0001D0, 1, 1, 0, -1);
    // blocksize=0 now latched: every sample switches
    sweep(24'h00001E, 24'h0001E0, 1, 1, 1, -1);
    sweep(24'h00001F, 24'h0001F0, 1, 1, 0, -1);

    // sample 32, reset at rd=7
    strobe = 1'b1;
    re_in  = 24'hCAFE01;
    im_in  = 24'hBEEF02;
    tick();
    strobe = 1'b0;
    chk("s32_bank", bank, 1);
    chk("s32_swap", swap, 1);
    for (int i = 0; i < 7; i++) tick();
    chk("pre_rd", rd, 7);
    chk("pre_wr", wr, 4);
    chk("pre_sw", sw, 1);
    chk("pre_ovr", overrun, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_en", en, 0);
    chk("arst_sw", sw, 0);
    chk("arst_rd", rd, 0);
    chk("arst_wr", wr, 0);
    chk("arst_bank", bank, 0);
    chk("arst_ovr", overrun, 0);
    chk("arst_re", re, 0);
    exp_ovr = 1'b0;
    #2 rst_n = 1'b1;
    tick();

    // post-reset with blocksize=0: first sweep no swap, then every sweep swaps
    sweep(24'h777777, 24'h888888, 1, 0, 0, -1);
    sweep(24'h999999, 24'hAAAAAA, 1, 1, 1, -1);
    sweep(24'hBBBBBB, 24'hCCCCCC, 1, 1, 0, -1);
    tick();
    chk("end_en", en, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  // Safety net: the directed sequence is a few hundred cycles.
  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

endmodule
